// File: rtl/usb_rx_unstuff_ctrl_if.sv
// Handshake bundle between the NRZI decoder side and the Rx unstuff
// controller. The controller attaches through the slave modport; the
// upstream source (decoder / bench) attaches through the master modport.
interface usb_rx_unstuff_ctrl_if #(
    parameter int BYTE_BITS = 8
);
    localparam int CNT_W = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;

    logic             rx_active;
    logic             eop;
    logic             bit_strobe;
    logic             d_bit;
    logic             shift_enable;
    logic             data_bit;
    logic             byte_done;
    logic             stuff_skip;
    logic             stuff_err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output rx_active, eop, bit_strobe, d_bit,
        input  shift_enable, data_bit, byte_done, stuff_skip, stuff_err, bit_cnt
    );

    modport slave (
        input  rx_active, eop, bit_strobe, d_bit,
        output shift_enable, data_bit, byte_done, stuff_skip, stuff_err, bit_cnt
    );
endinterface

// File: rtl/usb_rx_unstuff_ctrl.sv
// USB Rx bit-unstuff sequencing controller.
// Drops the stuffed zero after every RUN_LEN consecutive ones, pulses
// shift_enable for each real data bit, counts bits per byte and flags
// stuffing violations (sticky until the next packet starts).
// Build option: define USB_RX_UNSTUFF_STRICT_EN to make a stuffing
// violation park the block in ERR for the rest of the packet; without it
// the offending bit is dropped like a stuffed zero and reception goes on.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet; strobes ignored, waiting for rx_active & !eop
// RUN   | accepting data bits, tracking the run of ones
// SKIP  | RUN_LEN ones seen; next strobed bit is the stuffed bit
// ERR   | stuffing violation (strict build only); strobes ignored
module usb_rx_unstuff_ctrl #(
    parameter int RUN_LEN   = 6,
    parameter int BYTE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    usb_rx_unstuff_ctrl_if.slave     bus
);
    localparam int CNT_W = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_BITS - 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RUN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state_q;
    logic [RUN_W-1:0] run_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             shift_enable_q;
    logic             data_bit_q;
    logic             byte_done_q;
    logic             stuff_skip_q;
    logic             stuff_err_q;

    logic             leave_d;
    logic             byte_end_d;
    logic             run_end_d;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [RUN_W-1:0] run_d;

    // Next values of the counters and the exit condition shared by all busy states.
    always_comb begin
        leave_d    = !bus.rx_active || bus.eop;
        byte_end_d = (bit_cnt_q == BYTE_LAST);
        run_end_d  = (run_q == RUN_LAST);
        bit_cnt_d  = byte_end_d ? '0 : bit_cnt_q + 1'b1;
        run_d      = run_end_d ? '0 : run_q + 1'b1;
    end

    // Controller FSM with registered, single-cycle output pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            run_q          <= '0;
            bit_cnt_q      <= '0;
            shift_enable_q <= 1'b0;
            data_bit_q     <= 1'b0;
            byte_done_q    <= 1'b0;
            stuff_skip_q   <= 1'b0;
            stuff_err_q    <= 1'b0;
        end else begin
            shift_enable_q <= 1'b0;
            byte_done_q    <= 1'b0;
            stuff_skip_q   <= 1'b0;

            if (state_q == IDLE) begin
                // A strobe in the rise cycle is not part of the packet.
                if (bus.rx_active && !bus.eop) begin
                    state_q     <= RUN;
                    stuff_err_q <= 1'b0;
                    run_q       <= '0;
                    bit_cnt_q   <= '0;
                end
            end else if (leave_d) begin
                // Partial bytes are abandoned; stuff_err survives for inspection.
                state_q   <= IDLE;
                run_q     <= '0;
                bit_cnt_q <= '0;
            end else if (bus.bit_strobe) begin
                case (state_q)
                    RUN: begin
                        shift_enable_q <= 1'b1;
                        data_bit_q     <= bus.d_bit;
                        bit_cnt_q      <= bit_cnt_d;
                        byte_done_q    <= byte_end_d;
                        if (!bus.d_bit) begin
                            run_q <= '0;
                        end else begin
                            run_q <= run_d;
                            if (run_end_d) begin
                                state_q <= SKIP;
                            end
                        end
                    end
                    SKIP: begin
                        run_q <= '0;
                        if (!bus.d_bit) begin
                            stuff_skip_q <= 1'b1;
                            state_q      <= RUN;
                        end else begin
                            stuff_err_q <= 1'b1;
`ifdef USB_RX_UNSTUFF_STRICT_EN
                            state_q      <= ERR;
`else
                            stuff_skip_q <= 1'b1;
                            state_q      <= RUN;
`endif
                        end
                    end
                    default: begin
                        // ERR: wait for the packet to end.
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign bus.shift_enable = shift_enable_q;
    assign bus.data_bit     = data_bit_q;
    assign bus.byte_done    = byte_done_q;
    assign bus.stuff_skip   = stuff_skip_q;
    assign bus.stuff_err    = stuff_err_q;
    assign bus.bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_usb_rx_unstuff_ctrl.sv
// Directed bench for usb_rx_unstuff_ctrl: a vector table of
// {inputs, expected outputs one cycle later} plus hand-written sequences
// for asynchronous reset and back-to-back byte counting.
module tb_usb_rx_unstuff_ctrl;
    logic clk;
    logic n_rst;

    usb_rx_unstuff_ctrl_if #(.BYTE_BITS(8)) bus ();

    usb_rx_unstuff_ctrl #(.RUN_LEN(6), .BYTE_BITS(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ra;
        logic       eop;
        logic       stb;
        logic       d;
        logic       se;
        logic       db;
        logic       bd;
        logic       ss;
        logic       err;
        logic [2:0] bc;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic add(input logic ra, input logic eop, input logic stb, input logic d,
                       input logic se, input logic db, input logic bd, input logic ss,
                       input logic err, input logic [2:0] bc);
        vec_t v;
        v.ra = ra; v.eop = eop; v.stb = stb; v.d = d;
        v.se = se; v.db = db; v.bd = bd; v.ss = ss; v.err = err; v.bc = bc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ra, input logic eop, input logic stb, input logic d);
        bus.rx_active  = ra;
        bus.eop        = eop;
        bus.bit_strobe = stb;
        bus.d_bit      = d;
    endtask

    function automatic logic [7:0] outs();
        return {1'b0, bus.shift_enable, bus.byte_done, bus.stuff_skip,
                bus.stuff_err, bus.bit_cnt};
    endfunction

    int se_cnt;
    int bd_cnt;
    int ss_cnt;

    initial begin
        // {ra, eop, stb, d} -> {se, db, bd, ss, err, bc}
        add(0,0,0,0, 0,0,0,0,0,0);
        add(1,0,1,1, 0,0,0,0,0,0);
        // clean byte 0xA5, LSB first
        add(1,0,1,1, 1,1,0,0,0,1);
        add(1,0,1,0, 1,0,0,0,0,2);
        add(1,0,1,1, 1,1,0,0,0,3);
        add(1,0,1,0, 1,0,0,0,0,4);
        add(1,0,1,0, 1,0,0,0,0,5);
        add(1,0,1,1, 1,1,0,0,0,6);
        add(1,0,1,0, 1,0,0,0,0,7);
        add(1,0,1,1, 1,1,1,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        // legal stuffing 1,1,1,1,1,1,0,1
        for (int k = 1; k <= 6; k++) add(1,0,1,1, 1,1,0,0,0,3'(k));
        add(1,0,1,0, 0,0,0,1,0,6);
        add(1,0,1,1, 1,1,0,0,0,7);
        add(0,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        // eop collision after 5 bits
        add(1,0,1,0, 1,0,0,0,0,1);
        add(1,0,1,1, 1,1,0,0,0,2);
        add(1,0,1,0, 1,0,0,0,0,3);
        add(1,0,1,1, 1,1,0,0,0,4);
        add(1,0,1,0, 1,0,0,0,0,5);
        add(1,1,1,1, 0,0,0,0,0,0);
        add(1,0,1,1, 0,0,0,0,0,0);
        // stuffing violation: seven ones
        for (int k = 1; k <= 6; k++) add(1,0,1,1, 1,1,0,0,0,3'(k));
`ifdef USB_RX_UNSTUFF_STRICT_EN
        add(1,0,1,1, 0,0,0,0,1,6);
        add(1,0,1,0, 0,0,0,0,1,6);
        add(1,0,1,1, 0,0,0,0,1,6);
`else
        add(1,0,1,1, 0,0,0,1,1,6);
        add(1,0,1,0, 1,0,0,0,1,7);
        add(1,0,1,1, 1,1,1,0,1,0);
`endif
        add(0,0,0,0, 0,0,0,0,1,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        // eop has priority, also blocks the IDLE->RUN rise
        add(1,1,0,0, 0,0,0,0,0,0);
        add(1,1,1,1, 0,0,0,0,0,0);
        add(1,0,1,1, 0,0,0,0,0,0);
        add(1,0,1,0, 1,0,0,0,0,1);

        drive(0,0,0,0);
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ra, vecs[i].eop, vecs[i].stb, vecs[i].d);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d outs", i), outs(),
                {1'b0, vecs[i].se, vecs[i].bd, vecs[i].ss, vecs[i].err, vecs[i].bc});
            if (vecs[i].se)
                chk($sformatf("vec%0d data_bit", i), {7'b0, bus.data_bit}, {7'b0, vecs[i].db});
        end

        // asynchronous reset mid-packet
        drive(0,0,0,0);
        @(posedge clk); #1;
        drive(1,0,0,0);
        @(posedge clk); #1;
        drive(1,0,1,1); @(posedge clk); #1;
        drive(1,0,1,0); @(posedge clk); #1;
        drive(1,0,1,1); @(posedge clk); #1;
        chk("pre_reset outs", outs(), 8'b0100_0011);
        #2 n_rst = 1'b0;
        #1;
        chk("async_reset outs", outs(), 8'h00);
        chk("async_reset data_bit", {7'b0, bus.data_bit}, 8'h00);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        drive(0,0,0,0);
        @(posedge clk); #1;
        chk("post_reset idle", outs(), 8'h00);
        drive(1,0,0,0);
        @(posedge clk); #1;
        drive(1,0,1,1);
        @(posedge clk); #1;
        chk("restart first bit", outs(), 8'b0100_0001);

        // back-to-back strobes: 15 more zeros complete two bytes
        se_cnt = 0; bd_cnt = 0; ss_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            drive(1,0,1,0);
            @(posedge clk); #1;
            se_cnt += int'(bus.shift_enable);
            bd_cnt += int'(bus.byte_done);
            ss_cnt += int'(bus.stuff_skip);
        end
        drive(1,0,0,0);
        chk("b2b shift_enable count", 8'(se_cnt), 8'd15);
        chk("b2b byte_done count", 8'(bd_cnt), 8'd2);
        chk("b2b stuff_skip count", 8'(ss_cnt), 8'd0);
        chk("b2b final bit_cnt", {5'b0, bus.bit_cnt}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/usb_rx_unstuff_ctrl.md
# usb_rx_unstuff_ctrl

Sequencing controller for the USB Rx bit-unstuff path. It consumes the NRZI-decoded bit stream one strobe at a time and tracks consecutive ones with an internal run counter. It drops the stuffed zero after every run of `RUN_LEN` ones and tells the Rx shift register when a real data bit is available. It sits between the NRZI decoder and the Rx shift register / byte assembler. It also counts data bits per byte and flags stuffing violations.

## Interface

Parameters:
- `RUN_LEN`, default 6: number of consecutive ones after which one stuffed bit follows.
- `BYTE_BITS`, default 8: data bits per byte.

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous, active-low reset
- `rx_active`  in  1  level; packet in progress (SYNC already stripped)
- `eop`  in  1  level; end-of-packet detected
- `bit_strobe`  in  1  one-cycle pulse; `d_bit` valid this cycle
- `d_bit`  in  1  NRZI-decoded bit
- `shift_enable`  out  1  one-cycle pulse; `data_bit` is a real data bit to shift in
- `data_bit`  out  1  registered copy of the accepted bit
- `byte_done`  out  1  one-cycle pulse alongside the `shift_enable` of the last bit of a byte
- `stuff_skip`  out  1  one-cycle pulse; a stuffed bit was dropped
- `stuff_err`  out  1  level; stuffing violation seen in the current or most recent packet
- `bit_cnt`  out  `$clog2(BYTE_BITS)`  data bits accepted in the current byte

## Operation

- **Reset values.** All outputs are 0. The run counter is 0. The state is IDLE.
- **States:** IDLE, RUN, SKIP, ERR.
- **IDLE**
  - Strobes are ignored.
  - When `rx_active`=1 and `eop`=0, the block moves to RUN. On that transition `stuff_err` clears and the run counter and `bit_cnt` are zeroed.
- **RUN**, on `bit_strobe`:
  - The bit is accepted: `shift_enable` and `data_bit` are set, and `bit_cnt` increments.
  - When `bit_cnt` is at `BYTE_BITS`-1, `bit_cnt` wraps to 0 and `byte_done` pulses.
  - `d_bit`=0 clears the run counter.
  - `d_bit`=1 increments the run counter. When it reaches `RUN_LEN`, the bit is still accepted, the run counter goes to 0, and the next state is SKIP.
- **SKIP**, on `bit_strobe`:
  - The bit is never shifted in and `bit_cnt` is unchanged.
  - `d_bit`=0: `stuff_skip` pulses, then back to RUN.
  - `d_bit`=1: handled according to the Configuration section.
- **ERR**
  - Strobes are ignored and no outputs pulse.
  - `stuff_err` stays 1.
- **Priority, in every non-IDLE state:**
  1. `rx_active`=0 → IDLE.
  2. else `eop`=1 → IDLE.
  3. else process the strobe.
- **Strobe coinciding with leaving.** A strobe in the same cycle as `rx_active`=0 or `eop`=1 is discarded: no pulses.
- **Leaving to IDLE** zeroes the run counter and `bit_cnt`.
  - A partial byte produces no `byte_done`.
  - `stuff_err` holds until the next IDLE→RUN transition.
- **Run counter** is `$clog2(RUN_LEN+1)` bits wide and saturates by construction; it never exceeds `RUN_LEN`.

## Timing

- All outputs are registered.
- A strobe in cycle N produces `shift_enable`/`data_bit`/`byte_done`/`stuff_skip` in cycle N+1, each high for exactly one cycle.
- `bit_cnt` and `stuff_err` update in cycle N+1.
- Back-to-back strobes, one every cycle, are supported with no loss.
- The `rx_active` rise in cycle N puts the block in RUN at N+1. A strobe in cycle N itself is ignored.
- Reset asserted mid-packet forces all outputs to 0 and the state to IDLE immediately, without waiting for a clock edge.
- `stuff_skip` and `shift_enable` are mutually exclusive in any cycle.

## Configuration

- Macro: `USB_RX_UNSTUFF_STRICT_EN`.
- **Defined (strict):** in SKIP, `d_bit`=1 sets `stuff_err` at N+1 and the block enters ERR. It stays in ERR until `rx_active`=0 or `eop`=1, then goes to IDLE.
- **Undefined (lenient):** in SKIP, `d_bit`=1 is treated like a stuffed zero. It is dropped, `stuff_skip` pulses, the run counter is 0, and the block returns to RUN. `stuff_err` is still set (sticky) but reception continues. ERR is unreachable.

## Test plan

1. **Clean byte.** `rx_active`=1, strobe 8 bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1) → 8 `shift_enable` pulses; `data_bit` sequence matches; `byte_done` pulses with the 8th; `bit_cnt` returns to 0; no `stuff_skip`.
2. **Legal stuffing.** Strobe 1,1,1,1,1,1,0,1 → 7 `shift_enable` pulses (six 1s, then the final 1); one `stuff_skip` on the 0; `bit_cnt`=7; `stuff_err`=0.
3. **Strict violation** (macro defined). Strobe seven 1s → 6 `shift_enable` pulses; `stuff_err`=1 at N+1 of the 7th strobe; further strobes produce nothing. Drop `rx_active` → IDLE with `stuff_err` still 1. Raise `rx_active` → `stuff_err`=0.
4. **Lenient violation** (macro undefined). Strobe seven 1s then 0,1 → 6 + 2 `shift_enable` pulses; one `stuff_skip`; `stuff_err`=1; reception continues.
5. **EOP collision.** After 5 bits, assert `eop` together with a strobe → no pulse for that strobe; `bit_cnt`=0 next cycle; no `byte_done`; state IDLE.
6. **Reset mid-packet.** Assert `n_rst`=0 after 3 accepted bits and hold a strobe → all outputs 0 without a clock edge. After release, `rx_active`=1 restarts cleanly with `bit_cnt` from 0.
